// File: rtl/pcie_link_status_2_pkg.sv
// Shared definitions for the PCIe Link Status 2 register: bit positions,
// equalization FSM states, the latched link-attribute bundle and RW1C helpers.
package pcie_link_status_2_pkg;

  localparam int LS2_DE_EMPH_MSB  = 15;
  localparam int LS2_DE_EMPH_LSB  = 12;
  localparam int LS2_EQ_COMPLETE  = 11;
  localparam int LS2_EQ_PH1_OK    = 10;
  localparam int LS2_EQ_PH2_OK    = 9;
  localparam int LS2_EQ_PH3_OK    = 8;
  localparam int LS2_EQ_REQUEST   = 7;
  localparam int LS2_RETIMER      = 6;
  localparam int LS2_TWO_RETIMERS = 5;
  localparam int LS2_CROSSLINK    = 4;
  localparam int LS2_FLIT         = 3;
  localparam int LS2_RSVDZ        = 2;
  localparam int LS2_DS_PRESENT   = 1;
  localparam int LS2_DRS_RCVD     = 0;

  localparam logic [15:0] LS2_RW1C_MASK = 16'h0081;

  typedef enum logic [2:0] {
    EQ_IDLE,
    EQ_PH1,
    EQ_PH2,
    EQ_PH3,
    EQ_DONE
  } ls2_eq_state_t;

  typedef struct packed {
    logic retimer;
    logic two_retimers;
    logic crosslink;
    logic flit;
    logic ds_present;
  } ls2_link_attr_t;

  // A hardware set in the same cycle as a write-1-to-clear keeps the bit set.
  function automatic logic rw1c_next(input logic set, input logic cur, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/link_status_2_eq_tracker.sv
// Tracks the 8 GT/s equalization sequence and owns Link Status 2 bits 11:8
// (eq complete, phase 1/2/3 successful).
module link_status_2_eq_tracker
  import pcie_link_status_2_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eq_start_i,
  input  logic [2:0] eq_phase_ok_i,
  input  logic       eq_abort_i,
  output logic [3:0] eq_bits_o
);

  ls2_eq_state_t state_q;
  // Layout matches the register: [3]=complete, [2]=ph1, [1]=ph2, [0]=ph3.
  logic [3:0]    bits_q;

  // Start beats abort and phase results; abort leaves the earned bits intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EQ_IDLE;
      bits_q  <= 4'b0000;
    end else if (eq_start_i) begin
      state_q <= EQ_PH1;
      bits_q  <= 4'b0000;
    end else if (eq_abort_i) begin
      state_q <= EQ_IDLE;
    end else begin
      case (state_q)
        EQ_PH1: if (eq_phase_ok_i[0]) begin
          bits_q[2] <= 1'b1;
          state_q   <= EQ_PH2;
        end
        EQ_PH2: if (eq_phase_ok_i[1]) begin
          bits_q[1] <= 1'b1;
          state_q   <= EQ_PH3;
        end
        EQ_PH3: if (eq_phase_ok_i[2]) begin
          bits_q[0] <= 1'b1;
          bits_q[3] <= 1'b1;
          state_q   <= EQ_DONE;
        end
        default: ;
      endcase
    end
  end

  assign eq_bits_o = bits_q;

endmodule

// File: rtl/link_status_2_register_ctrl.sv
// Hardware-side owner of the PCIe Link Status 2 register: collects PHY/LTSSM
// status, latches link attributes at link-up and serves RO/RW1C config accesses.
module link_status_2_register_ctrl
  import pcie_link_status_2_pkg::*;
#(
  parameter bit RETIMER_SUPPORT = 1'b1,
  parameter bit FLIT_SUPPORT    = 1'b1,
  parameter bit DRS_SUPPORT     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_up,
  input  logic [3:0]  de_emphasis_level,
  input  logic        eq_start,
  input  logic [2:0]  eq_phase_ok,
  input  logic        eq_abort,
  input  logic        hw_eq_request,
  input  logic        retimer_det,
  input  logic        two_retimer_det,
  input  logic        crosslink_res,
  input  logic        flit_mode,
  input  logic        ds_comp_present,
  input  logic        drs_rcvd,
  input  logic        cfg_rd,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_be,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [15:0] cfg_rdata,
  output logic [15:0] link_status_2
);

  logic [3:0]     de_emph_q;
  logic [3:0]     eq_bits;
  logic           link_up_q;
  ls2_link_attr_t attr_q, attr_d;
  logic           eq_req_q, eq_req_d;
  logic           drs_q, drs_d;
  logic           cfg_ack_q;
  logic [15:0]    cfg_rdata_q;
  logic [15:0]    wr_clr;
  logic [15:0]    ls2_image;
  logic           cfg_req;
  logic           unused_inputs;

  link_status_2_eq_tracker u_eq_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .eq_start_i    (eq_start),
    .eq_phase_ok_i (eq_phase_ok),
    .eq_abort_i    (eq_abort),
    .eq_bits_o     (eq_bits)
  );

  assign cfg_req = cfg_rd | cfg_wr;
  assign wr_clr  = (cfg_wr && cfg_be[0]) ? (cfg_wdata & LS2_RW1C_MASK) : 16'h0000;

  // Attributes are sampled once on the link-up rising edge, then frozen until link-down.
  always_comb begin
    attr_d = attr_q;
    if (link_up && !link_up_q) begin
      attr_d.retimer      = RETIMER_SUPPORT ? (retimer_det | two_retimer_det) : 1'b0;
      attr_d.two_retimers = RETIMER_SUPPORT ? two_retimer_det : 1'b0;
      attr_d.crosslink    = crosslink_res;
      attr_d.flit         = FLIT_SUPPORT ? flit_mode : 1'b0;
      attr_d.ds_present   = ds_comp_present;
    end else if (!link_up) begin
      attr_d = '0;
    end
  end

  always_comb begin
    eq_req_d = rw1c_next(hw_eq_request, eq_req_q, wr_clr[LS2_EQ_REQUEST]);
    drs_d    = DRS_SUPPORT ? rw1c_next(drs_rcvd, drs_q, wr_clr[LS2_DRS_RCVD]) : 1'b0;
  end

  always_comb begin
    ls2_image                                   = 16'h0000;
    ls2_image[LS2_DE_EMPH_MSB:LS2_DE_EMPH_LSB]  = de_emph_q;
    ls2_image[LS2_EQ_COMPLETE:LS2_EQ_PH3_OK]    = eq_bits;
    ls2_image[LS2_EQ_REQUEST]                   = eq_req_q;
    ls2_image[LS2_RETIMER]                      = attr_q.retimer;
    ls2_image[LS2_TWO_RETIMERS]                 = attr_q.two_retimers;
    ls2_image[LS2_CROSSLINK]                    = attr_q.crosslink;
    ls2_image[LS2_FLIT]                         = attr_q.flit;
    ls2_image[LS2_RSVDZ]                        = 1'b0;
    ls2_image[LS2_DS_PRESENT]                   = attr_q.ds_present;
    ls2_image[LS2_DRS_RCVD]                     = drs_q;
  end

  // Read data captures the image before any write in the same cycle takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_emph_q   <= 4'h0;
      link_up_q   <= 1'b0;
      attr_q      <= '0;
      eq_req_q    <= 1'b0;
      drs_q       <= 1'b0;
      cfg_ack_q   <= 1'b0;
      cfg_rdata_q <= 16'h0000;
    end else begin
      de_emph_q   <= de_emphasis_level;
      link_up_q   <= link_up;
      attr_q      <= attr_d;
      eq_req_q    <= eq_req_d;
      drs_q       <= drs_d;
      cfg_ack_q   <= cfg_req;
      cfg_rdata_q <= cfg_req ? ls2_image : 16'h0000;
    end
  end

  assign cfg_ack       = cfg_ack_q;
  assign cfg_rdata     = cfg_rdata_q;
  assign link_status_2 = ls2_image;

  assign unused_inputs = ^{cfg_be[1], wr_clr[15:8], wr_clr[6:1]};

endmodule

// File: tb/tb_link_status_2_register_ctrl.sv
// Directed self-checking bench for link_status_2_register_ctrl with
// hand-computed register images.
module tb_link_status_2_register_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_up;
  logic [3:0]  de_emphasis_level;
  logic        eq_start;
  logic [2:0]  eq_phase_ok;
  logic        eq_abort;
  logic        hw_eq_request;
  logic        retimer_det;
  logic        two_retimer_det;
  logic        crosslink_res;
  logic        flit_mode;
  logic        ds_comp_present;
  logic        drs_rcvd;
  logic        cfg_rd;
  logic        cfg_wr;
  logic [1:0]  cfg_be;
  logic [15:0] cfg_wdata;
  logic        cfg_ack;
  logic [15:0] cfg_rdata;
  logic [15:0] link_status_2;

  int assertCount = 0;
  int failCount   = 0;

  link_status_2_register_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .link_up           (link_up),
    .de_emphasis_level (de_emphasis_level),
    .eq_start          (eq_start),
    .eq_phase_ok       (eq_phase_ok),
    .eq_abort          (eq_abort),
    .hw_eq_request     (hw_eq_request),
    .retimer_det       (retimer_det),
    .two_retimer_det   (two_retimer_det),
    .crosslink_res     (crosslink_res),
    .flit_mode         (flit_mode),
    .ds_comp_present   (ds_comp_present),
    .drs_rcvd          (drs_rcvd),
    .cfg_rd            (cfg_rd),
    .cfg_wr            (cfg_wr),
    .cfg_be            (cfg_be),
    .cfg_wdata         (cfg_wdata),
    .cfg_ack           (cfg_ack),
    .cfg_rdata         (cfg_rdata),
    .link_status_2     (link_status_2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearPulses();
    eq_start      = 1'b0;
    eq_phase_ok   = 3'b000;
    eq_abort      = 1'b0;
    hw_eq_request = 1'b0;
    drs_rcvd      = 1'b0;
    cfg_rd        = 1'b0;
    cfg_wr        = 1'b0;
    cfg_be        = 2'b00;
    cfg_wdata     = 16'h0000;
  endtask

  task automatic applyStimulus(input logic [2:0] phaseOk, input logic start, input logic abort);
    eq_phase_ok = phaseOk;
    eq_start    = start;
    eq_abort    = abort;
    tick();
    clearPulses();
  endtask

  task automatic cfgAccess(input logic rd, input logic wr, input logic [1:0] be, input logic [15:0] wdata,
                           input logic hwReq, input logic drs);
    cfg_rd        = rd;
    cfg_wr        = wr;
    cfg_be        = be;
    cfg_wdata     = wdata;
    hw_eq_request = hwReq;
    drs_rcvd      = drs;
    tick();
    clearPulses();
  endtask

  initial begin
    rst_n             = 1'b0;
    link_up           = 1'b0;
    de_emphasis_level = 4'h0;
    retimer_det       = 1'b0;
    two_retimer_det   = 1'b0;
    crosslink_res     = 1'b0;
    flit_mode         = 1'b0;
    ds_comp_present   = 1'b0;
    clearPulses();

    #12;
    checkOutput("reset_ls2", link_status_2, 16'h0000);
    checkOutput("reset_ack", {15'd0, cfg_ack}, 16'h0000);
    checkOutput("reset_rdata", cfg_rdata, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // De-emphasis follows its input with one cycle of latency
    de_emphasis_level = 4'hA;
    tick();
    checkOutput("de_emph", link_status_2, 16'hA000);
    de_emphasis_level = 4'h0;
    tick();
    checkOutput("de_emph_back", link_status_2, 16'h0000);

    // Full equalization, with an out-of-order phase result ignored
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("eq_start", link_status_2, 16'h0000);
    applyStimulus(3'b010, 1'b0, 1'b0);
    checkOutput("eq_wrong_phase", link_status_2, 16'h0000);
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("eq_ph1", link_status_2, 16'h0400);
    applyStimulus(3'b010, 1'b0, 1'b0);
    checkOutput("eq_ph2", link_status_2, 16'h0600);
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("eq_done", link_status_2, 16'h0F00);
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("eq_done_hold", link_status_2, 16'h0F00);

    // Abort keeps bits, idle ignores phases, a new start clears
    applyStimulus(3'b000, 1'b1, 1'b0);
    checkOutput("eq_restart", link_status_2, 16'h0000);
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("abort_ph1", link_status_2, 16'h0400);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkOutput("abort_keep", link_status_2, 16'h0400);
    applyStimulus(3'b010, 1'b0, 1'b0);
    checkOutput("abort_idle", link_status_2, 16'h0400);
    applyStimulus(3'b000, 1'b1, 1'b1);
    checkOutput("start_over_abort", link_status_2, 16'h0000);
    applyStimulus(3'b001, 1'b1, 1'b0);
    checkOutput("start_over_phase", link_status_2, 16'h0000);
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("start_to_ph1", link_status_2, 16'h0400);
    applyStimulus(3'b000, 1'b1, 1'b0);

    // Link attribute latch
    retimer_det = 1'b1;
    flit_mode   = 1'b1;
    link_up     = 1'b1;
    tick();
    checkOutput("link_latch", link_status_2, 16'h0048);
    retimer_det     = 1'b0;
    flit_mode       = 1'b0;
    ds_comp_present = 1'b1;
    tick();
    checkOutput("link_hold", link_status_2, 16'h0048);
    link_up = 1'b0;
    tick();
    checkOutput("link_down", link_status_2, 16'h0000);
    two_retimer_det = 1'b1;
    crosslink_res   = 1'b1;
    link_up         = 1'b1;
    tick();
    checkOutput("two_retimer_forces", link_status_2, 16'h0072);
    link_up         = 1'b0;
    two_retimer_det = 1'b0;
    crosslink_res   = 1'b0;
    ds_comp_present = 1'b0;
    tick();
    checkOutput("link_down2", link_status_2, 16'h0000);

    // DRS RW1C
    cfgAccess(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    checkOutput("drs_set", link_status_2, 16'h0001);
    cfgAccess(1'b0, 1'b1, 2'b01, 16'h0001, 1'b0, 1'b0);
    checkOutput("wr_ack", {15'd0, cfg_ack}, 16'h0001);
    checkOutput("wr_rdata_pre", cfg_rdata, 16'h0001);
    checkOutput("drs_clear", link_status_2, 16'h0000);
    tick();
    checkOutput("ack_one_cycle", {15'd0, cfg_ack}, 16'h0000);
    checkOutput("rdata_idle", cfg_rdata, 16'h0000);
    cfgAccess(1'b0, 1'b1, 2'b01, 16'h0001, 1'b0, 1'b1);
    checkOutput("set_wins", link_status_2, 16'h0001);
    cfgAccess(1'b0, 1'b1, 2'b10, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("be1_only_ack", {15'd0, cfg_ack}, 16'h0001);
    checkOutput("be1_no_effect", link_status_2, 16'h0001);

    // Read colliding with a hardware set, then clear all RW1C bits
    retimer_det = 1'b1;
    link_up     = 1'b1;
    tick();
    checkOutput("link_up_again", link_status_2, 16'h0041);
    cfgAccess(1'b1, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0);
    checkOutput("rd_ack", {15'd0, cfg_ack}, 16'h0001);
    checkOutput("rd_pre_set", cfg_rdata, 16'h0041);
    checkOutput("eq_req_set", link_status_2, 16'h00C1);
    cfgAccess(1'b1, 1'b1, 2'b11, 16'hFFFF, 1'b0, 1'b0);
    checkOutput("rdwr_ack", {15'd0, cfg_ack}, 16'h0001);
    checkOutput("rdwr_pre", cfg_rdata, 16'h00C1);
    checkOutput("wr_ffff", link_status_2, 16'h0040);

    // Back-to-back reads each get an ack
    cfg_rd = 1'b1;
    tick();
    checkOutput("b2b_ack1", {15'd0, cfg_ack}, 16'h0001);
    tick();
    checkOutput("b2b_ack2", {15'd0, cfg_ack}, 16'h0001);
    cfg_rd = 1'b0;
    tick();
    checkOutput("b2b_ack_end", {15'd0, cfg_ack}, 16'h0000);

    // DRS survives link down
    cfgAccess(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b1);
    link_up     = 1'b0;
    retimer_det = 1'b0;
    tick();
    checkOutput("drs_keep_linkdown", link_status_2, 16'h0001);

    // Reset in the middle of equalization and of an access
    applyStimulus(3'b000, 1'b1, 1'b0);
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("pre_reset", link_status_2, 16'h0401);
    cfg_rd = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_ls2", link_status_2, 16'h0000);
    checkOutput("mid_reset_ack", {15'd0, cfg_ack}, 16'h0000);
    tick();
    cfg_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_ack", {15'd0, cfg_ack}, 16'h0000);
    applyStimulus(3'b010, 1'b0, 1'b0);
    checkOutput("post_reset_idle", link_status_2, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
